// File: rtl/bus_arbiter_2to1.sv
// Round-robin arbiter that shares one datapath resource between two requesters
// (typically instruction fetch = 0, data access = 1). It owns the select line of
// the shared 2:1 data mux and enforces a hold limit so neither side can starve
// the other.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   req0     - request from requester 0, held high until its transaction ends
//   req1     - request from requester 1
//   done     - one-cycle pulse from the resource: current transaction complete
//   data0    - word from requester 0
//   data1    - word from requester 1
//   grant0   - registered grant to requester 0
//   grant1   - registered grant to requester 1
//   sel      - registered mux select (0 = data0, 1 = data1)
//   data_out - combinational mux output, sel ? data1 : data0
//   busy     - grant0 | grant1
//   timeout  - one-cycle pulse after a grant is force-released by the hold limit
`timescale 1ns / 1ps

module bus_arbiter_2to1 #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_HOLD   = 8,   // 0 disables the hold limit
  parameter int unsigned CNT_WIDTH  = 4    // 2**CNT_WIDTH must exceed MAX_HOLD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  grant0,
  output logic                  grant1,
  output logic                  sel,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  timeout
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } state_e;

  // Counter value on the last permitted cycle of a grant.
  localparam logic [CNT_WIDTH-1:0] HoldLast =
      CNT_WIDTH'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));
  localparam logic HoldEn = (MAX_HOLD != 0);

  state_e               state_q, state_d;
  logic                 last_q, last_d;    // index of the most recently granted requester
  logic                 sel_q, sel_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic cur_req;
  logic limit_hit;
  logic release_grant;
  logic new_grant;

  // Round-robin pick: a contended request goes to the side not served last.
  function automatic state_e arbitrate(input logic r0, input logic r1, input logic last);
    state_e pick;
    if (r0 && r1) begin
      pick = last ? StGnt0 : StGnt1;
    end else if (r0) begin
      pick = StGnt0;
    end else if (r1) begin
      pick = StGnt1;
    end else begin
      pick = StIdle;
    end
    return pick;
  endfunction

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    sel_d         = sel_q;
    timeout_d     = 1'b0;
    cnt_d         = cnt_q;
    cur_req       = 1'b0;
    limit_hit     = 1'b0;
    release_grant = 1'b0;

    unique case (state_q)
      StIdle: begin
        // done is ignored here; only requests matter.
        state_d = arbitrate(req0, req1, last_q);
      end
      StGnt0, StGnt1: begin
        cur_req       = (state_q == StGnt0) ? req0 : req1;
        limit_hit     = HoldEn && (cnt_q == HoldLast);
        release_grant = done || !cur_req || limit_hit;
        if (release_grant) begin
          // No idle bubble: re-arbitrate on the release cycle itself.
          state_d   = arbitrate(req0, req1, last_q);
          // Only a pure limit release counts as forced; done or an abandoned
          // request on the same cycle make it a normal release.
          timeout_d = limit_hit && !done && cur_req;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    new_grant = (state_d != StIdle) && ((state_q == StIdle) || release_grant);
    if (new_grant) begin
      cnt_d  = '0;
      last_d = (state_d == StGnt1);
      sel_d  = (state_d == StGnt1);
    end else if (state_d == StIdle) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;  // requester 0 wins the first contention
      sel_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant0   = (state_q == StGnt0);
  assign grant1   = (state_q == StGnt1);
  assign busy     = grant0 | grant1;
  assign sel      = sel_q;
  assign timeout  = timeout_q;
  assign data_out = sel_q ? data1 : data0;

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Directed bench for bus_arbiter_2to1. Each cycle the stimulus process drives the
// inputs for the next edge and queues the outputs expected in the current cycle;
// the monitor pops one entry per falling edge and compares.
`timescale 1ns / 1ps

module tb_bus_arbiter_2to1;

  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] D0 = 16'hA5A5;
  localparam logic [DW-1:0] D1 = 16'h1234;

  logic          clk;
  logic          rst_n;
  logic          req0, req1, done;
  logic [DW-1:0] data0, data1;
  logic          grant0, grant1, sel, busy, timeout;
  logic [DW-1:0] data_out;

  typedef struct packed {
    logic [7:0] test;
    logic [3:0] exp;   // {grant0, grant1, sel, timeout}
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  int   cur_test;

  bus_arbiter_2to1 #(
    .DATA_WIDTH(DW),
    .MAX_HOLD  (8),
    .CNT_WIDTH (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .done    (done),
    .data0   (data0),
    .data1   (data1),
    .grant0  (grant0),
    .grant1  (grant1),
    .sel     (sel),
    .data_out(data_out),
    .busy    (busy),
    .timeout (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs set now are sampled at the next edge; e is this cycle's output.
  task automatic cyc(input logic r0, input logic r1, input logic d, input logic [3:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    req0 = r0;
    req1 = r1;
    done = d;
    x.test = 8'(cur_test);
    x.exp  = e;
    exp_q.push_back(x);
  endtask

  // Reset asserted between edges: outputs must already be clear at the next
  // falling edge, before any rising edge.
  task automatic do_reset(input logic r0, input logic r1);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    req0   = r0;
    req1   = r1;
    done   = 1'b0;
    x.test = 8'(cur_test);
    x.exp  = 4'b0000;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(x);
  endtask

  // Monitor
  initial begin
    exp_t          x;
    logic [3:0]    act;
    logic          exp_busy;
    logic [DW-1:0] exp_data;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        x        = exp_q.pop_front();
        act      = {grant0, grant1, sel, timeout};
        exp_busy = x.exp[3] | x.exp[2];
        exp_data = x.exp[1] ? D1 : D0;
        vectors++;
        if (act !== x.exp || busy !== exp_busy || data_out !== exp_data) begin
          miscompares++;
          $display("FAIL test%0d vec%0d: got g0,g1,sel,to=%b busy=%b data=%h, want %b busy=%b data=%h",
                   x.test, vectors, act, busy, data_out, x.exp, exp_busy, exp_data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req0        = 1'b0;
    req1        = 1'b0;
    done        = 1'b0;
    data0       = D0;
    data1       = D1;

    // 1: single requester 0, done ends the grant, sel stays 0 in idle.
    cur_test = 1;
    do_reset(1'b0, 1'b0);
    cyc(0, 0, 0, 4'b0000);
    cyc(1, 0, 0, 4'b0000);
    cyc(1, 0, 0, 4'b1000);
    cyc(1, 0, 0, 4'b1000);
    cyc(0, 0, 1, 4'b1000);
    cyc(0, 0, 0, 4'b0000);

    // 2: both from reset, 0 first, then 1 with no idle gap.
    cur_test = 2;
    do_reset(1'b0, 1'b0);
    cyc(1, 1, 0, 4'b0000);
    cyc(1, 1, 0, 4'b1000);
    cyc(1, 1, 1, 4'b1000);
    cyc(0, 1, 0, 4'b0110);
    cyc(0, 1, 0, 4'b0110);
    cyc(0, 0, 1, 4'b0110);
    cyc(0, 0, 0, 4'b0010);

    // 3: both held, done every third cycle, strict alternation.
    cur_test = 3;
    cyc(1, 1, 0, 4'b0010);
    cyc(1, 1, 0, 4'b1000);
    cyc(1, 1, 0, 4'b1000);
    cyc(1, 1, 1, 4'b1000);
    cyc(1, 1, 0, 4'b0110);
    cyc(1, 1, 0, 4'b0110);
    cyc(1, 1, 1, 4'b0110);
    cyc(1, 1, 0, 4'b1000);
    cyc(1, 1, 0, 4'b1000);
    cyc(1, 1, 1, 4'b1000);
    cyc(0, 0, 0, 4'b0110);
    cyc(0, 0, 0, 4'b0010);

    // 4: only req1, hold limit 8 forces release and timeout, then a done that
    // coincides with the limit gives no timeout.
    cur_test = 4;
    cyc(0, 1, 0, 4'b0010);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 4'b0110);
    cyc(0, 1, 0, 4'b0111);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 4'b0110);
    cyc(0, 1, 1, 4'b0110);
    cyc(0, 0, 0, 4'b0110);
    cyc(0, 0, 0, 4'b0010);

    // 5: req0 abandons while req1 pends -> GNT1, no timeout.
    cur_test = 5;
    cyc(1, 0, 0, 4'b0010);
    cyc(1, 1, 0, 4'b1000);
    cyc(0, 1, 0, 4'b1000);
    cyc(0, 1, 0, 4'b0110);

    // 6: async reset mid-GNT1, then contention goes to requester 0.
    cur_test = 6;
    do_reset(1'b1, 1'b1);
    cyc(1, 1, 0, 4'b1000);
    cyc(0, 0, 1, 4'b1000);
    cyc(0, 0, 0, 4'b0000);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_2to1.md
Name: bus_arbiter_2to1

Overview:
Round-robin arbiter that shares one 16-bit datapath resource, such as the memory/bus port, between two requesters. Typical requesters are instruction fetch (0) and data access (1). The block owns the select line of the shared 2:1 data multiplexer and steers the granted requester's 16-bit word to the resource. A hold-limit counter forces release so neither requester can starve the other.

Parameters:
DATA_WIDTH, 16, width of the multiplexed data words.
MAX_HOLD, 8, maximum cycles one grant may last before forced release; 0 disables the limit.
CNT_WIDTH, 4, width of the hold counter; must satisfy 2^CNT_WIDTH > MAX_HOLD.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
req0  input  1  request from requester 0; held high until the transaction ends.
req1  input  1  request from requester 1; same rules as req0.
done  input  1  resource signals that the current transaction is complete (one-cycle pulse).
data0  input  DATA_WIDTH  word from requester 0.
data1  input  DATA_WIDTH  word from requester 1.
grant0  output  1  registered grant to requester 0.
grant1  output  1  registered grant to requester 1.
sel  output  1  registered mux select: 0 = data0, 1 = data1.
data_out  output  DATA_WIDTH  combinational: sel ? data1 : data0.
busy  output  1  grant0 | grant1.
timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (async, any time including mid-grant):
  - state = IDLE; grant0 = grant1 = 0; sel = 0; timeout = 0; hold counter = 0.
  - last_served = 1, so requester 0 wins the first contention.
- FSM states: IDLE, GNT0, GNT1. grant0 = (state == GNT0), grant1 = (state == GNT1). All are registered.
- Arbitration function, evaluated in IDLE and on every release cycle:
  - Only req0 high -> GNT0.
  - Only req1 high -> GNT1.
  - Both high -> grant the requester != last_served.
  - Neither high -> IDLE.
- Latency: a request seen at edge N gives grant high after edge N, i.e. in cycle N+1.
- sel updates on the same edge as the new grant and holds its last value in IDLE.
- last_served updates to the granted index when a grant begins.
- Release condition in GNTx (any of the following):
  - done = 1;
  - reqx = 0 (requester abandoned);
  - MAX_HOLD != 0 and the hold counter == MAX_HOLD-1 with done = 0 (forced).
- On release, the next state comes from the arbitration function with updated last_served. There is no IDLE bubble:
  - GNT0 -> GNT1 happens directly if req1 is pending.
  - If only the same requester is still requesting, it is re-granted back-to-back and the hold counter restarts.
- Hold counter:
  - Cleared on entering any grant state.
  - Increments every cycle in GNTx without release.
  - Held at 0 in IDLE.
- timeout = 1 for exactly the cycle after a forced release. It never asserts on a release caused by done or by reqx dropping.
- done while in IDLE is ignored.
- Simultaneous done and the limit hit count as a normal release: no timeout.
- grant0 and grant1 are never high together.
- data_out is purely combinational from sel. It adds no latency.

Test Plan:
- Reset then req0 = 1 at cycle 2, done at cycle 5 -> grant0 = 1 in cycles 3..5, sel = 0, data_out = data0 (0xA5A5), IDLE at cycle 6, sel stays 0.
- req0 = req1 = 1 together from reset -> GNT0 first. On done, GNT1 on the next cycle with no idle gap. sel 0->1; data_out switches to data1 (0x1234).
- Both held high, done pulsed every 3 cycles -> grants alternate 0,1,0,1. No requester is served twice in a row.
- Only req1 held high, no done, MAX_HOLD = 8 -> grant1 high for exactly 8 cycles, then timeout pulse one cycle. Re-grant to 1 with the counter restarted.
- req0 drops mid-grant while req1 is pending -> GNT1 on the next edge, timeout = 0.
- rst_n low asynchronously mid-GNT1 -> grant1, sel, busy go low immediately without a clock edge. After release, both requesting -> GNT0 is granted first.
